// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV registers, a small TX FIFO
// and a START/DATA/STOP serialiser driving a registered TxD pin.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic        IoSel,
  output logic [31:0] IoReadData,
  output logic        TxD
);

  localparam int         PW       = $clog2(FIFO_DEPTH);
  localparam logic [3:0] FULL_CNT = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_r, state_next_s;
  logic [7:0]      fifo_mem_r [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [3:0]      count_r;
  logic            overflow_r;
  logic [15:0]     baud_div_r, bit_div_r, bit_div_next_s, eff_div_s;
  logic [15:0]     cnt_r, cnt_next_s;
  logic [2:0]      bit_idx_r, bit_idx_next_s;
  logic [7:0]      shreg_r, shreg_next_s, pop_data_s;
  logic            txd_r, txd_next_s;
  logic            wr_s, push_s, pop_s, empty_s, full_s, busy_s, bit_end_s;
  logic [1:0]      off_s;
  logic            unused_s;

  assign IoSel      = (Adr[31:4] == BASE_ADDR[31:4]);
  assign off_s      = Adr[3:2];
  assign wr_s       = MemWrite & IoSel;
  assign empty_s    = (count_r == 4'd0);
  assign full_s     = (count_r == FULL_CNT);
  assign push_s     = wr_s & (off_s == 2'd0) & ~full_s;
  assign busy_s     = (state_r != IDLE);
  assign bit_end_s  = (cnt_r == 16'd0);
  assign eff_div_s  = (baud_div_r == 16'd0) ? 16'd1 : baud_div_r;
  assign pop_data_s = fifo_mem_r[rd_ptr_r];
  assign TxD        = txd_r;
  assign unused_s   = ^{WriteData[31:16], Adr[1:0]};

  // Combinational register read mux.
  always_comb begin
    IoReadData = 32'd0;
    if (IoSel) begin
      case (off_s)
        2'd1:    IoReadData = {24'd0, count_r, overflow_r, busy_s, full_s, empty_s};
        2'd2:    IoReadData = {16'd0, baud_div_r};
        default: IoReadData = 32'd0;
      endcase
    end else begin
      IoReadData = 32'd0;
    end
  end

  // Control registers: sticky overflow and the baud divisor.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r <= 1'b0;
      baud_div_r <= DEFAULT_DIV;
    end else begin
      if (wr_s && off_s == 2'd0 && full_s) overflow_r <= 1'b1;
      else if (wr_s && off_s == 2'd1)      overflow_r <= 1'b0;
      if (wr_s && off_s == 2'd2) baud_div_r <= WriteData[15:0];
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_s) fifo_mem_r[wr_ptr_r] <= WriteData[7:0];
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= 4'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 4'd1;
        2'b01:   count_r <= count_r - 4'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Serialiser state register; TxD is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 16'd0;
      bit_idx_r <= 3'd0;
      shreg_r   <= 8'd0;
      bit_div_r <= 16'd1;
      txd_r     <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      bit_idx_r <= bit_idx_next_s;
      shreg_r   <= shreg_next_s;
      bit_div_r <= bit_div_next_s;
      txd_r     <= txd_next_s;
    end
  end

  // Next-state logic; txd_next_s is the line level for the coming cycle.
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    bit_idx_next_s = bit_idx_r;
    shreg_next_s   = shreg_r;
    bit_div_next_s = bit_div_r;
    txd_next_s     = txd_r;
    pop_s          = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s          = 1'b1;
          shreg_next_s   = pop_data_s;
          bit_div_next_s = eff_div_s;
          cnt_next_s     = eff_div_s - 16'd1;
          state_next_s   = START;
          txd_next_s     = 1'b0;
        end else begin
          txd_next_s     = 1'b1;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_next_s   = DATA;
          bit_idx_next_s = 3'd0;
          cnt_next_s     = bit_div_r - 16'd1;
          txd_next_s     = shreg_r[0];
        end else begin
          cnt_next_s     = cnt_r - 16'd1;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          cnt_next_s = bit_div_r - 16'd1;
          if (bit_idx_r == 3'd7) begin
            state_next_s   = STOP;
            txd_next_s     = 1'b1;
          end else begin
            bit_idx_next_s = bit_idx_r + 3'd1;
            shreg_next_s   = {1'b0, shreg_r[7:1]};
            txd_next_s     = shreg_r[1];
          end
        end else begin
          cnt_next_s = cnt_r - 16'd1;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          if (!empty_s) begin
            pop_s          = 1'b1;
            shreg_next_s   = pop_data_s;
            bit_div_next_s = eff_div_s;
            cnt_next_s     = eff_div_s - 16'd1;
            state_next_s   = START;
            txd_next_s     = 1'b0;
          end else begin
            state_next_s   = IDLE;
            txd_next_s     = 1'b1;
          end
        end else begin
          cnt_next_s = cnt_r - 16'd1;
        end
      end
      default: begin
        state_next_s = IDLE;
        txd_next_s   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a queue-based line/FIFO model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE  = 32'h0000_FF00;
  localparam logic [31:0] A_TX  = BASE + 32'h0;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_DIV = BASE + 32'h8;
  localparam logic [31:0] A_RSV = BASE + 32'hC;
  localparam int          DEPTH = 4;
  localparam logic [15:0] DEFDIV = 16'd434;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Adr = A_ST;
  logic [31:0] WriteData = 32'd0;
  logic        IoSel;
  logic [31:0] IoReadData;
  logic        TxD;

  int checks = 0;
  int errors = 0;

  uart_tx_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEFDIV)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr),
    .WriteData(WriteData), .IoSel(IoSel), .IoReadData(IoReadData), .TxD(TxD)
  );

  always #5 clk = ~clk;

  // Model: pending bytes, and the line level for every remaining cycle of the current frame.
  logic [7:0]  q[$];
  bit          wave[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_div = DEFDIV;
  bit          m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_txd();
    return (wave.size() != 0) ? wave[0] : 1'b1;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd1: return {24'd0, 4'(q.size()), m_ovf, wave.size() != 0, q.size() == DEPTH, q.size() == 0};
      2'd2: return {16'd0, m_div};
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model across the coming edge using the inputs now applied.
  task automatic model_step();
    bit          full_before;
    logic [15:0] d;
    logic [7:0]  b;
    if (reset) begin
      q.delete(); wave.delete();
      m_ovf = 1'b0; m_div = DEFDIV; m_valid = 1'b1;
    end else if (m_valid) begin
      full_before = (q.size() == DEPTH);
      if (wave.size() != 0) void'(wave.pop_front());
      if (wave.size() == 0 && q.size() != 0) begin
        b = q.pop_front();
        d = (m_div == 16'd0) ? 16'd1 : m_div;
        for (int k = 0; k < 10; k++)
          for (int c = 0; c < int'(d); c++)
            wave.push_back(k == 0 ? 1'b0 : (k == 9 ? 1'b1 : b[k-1]));
      end
      if (MemWrite && Adr[31:4] == BASE[31:4]) begin
        case (Adr[3:2])
          2'd0: if (full_before) m_ovf = 1'b1; else q.push_back(WriteData[7:0]);
          2'd1: m_ovf = 1'b0;
          2'd2: m_div = WriteData[15:0];
          default: ;
        endcase
      end
    end
  endtask

  // Compare process: outputs sampled on the falling edge, then the model advances.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("txd", {31'd0, TxD}, {31'd0, exp_txd()});
        check("iosel", {31'd0, IoSel}, {31'd0, Adr[31:4] == BASE[31:4]});
        check("rdata", IoReadData, model_read(Adr));
      end
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; Adr = a; WriteData = d;
    tick();
    MemWrite = 1'b0; Adr = A_ST; WriteData = 32'd0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    Adr = a; #1;
    check(name, IoReadData, exp);
    Adr = A_ST;
  endtask

  initial begin
    ticks(2);
    reset = 1'b0;
    tick();
    rd("rst_status", A_ST, 32'h0000_0001);
    rd("rst_div", A_DIV, 32'd434);
    check("rst_txd", {31'd0, TxD}, 32'd1);

    // Single 0x55 frame at DIV=4: 10 bits alternating 0/1, 4 cycles each.
    wr(A_DIV, 32'd4);
    wr(A_TX, 32'h55);
    tick();
    for (int i = 0; i < 40; i++) begin
      check("frame55", {31'd0, TxD}, 32'((i / 4) % 2));
      tick();
    end
    rd("idle_after55", A_ST, 32'h0000_0001);

    // Back-to-back frames: stop bit of 0x41 runs straight into start bit of 0x42.
    MemWrite = 1'b1; Adr = A_TX; WriteData = 32'h41; tick();
    WriteData = 32'h42; tick();
    MemWrite = 1'b0; Adr = A_ST;
    for (int i = 0; i < 80; i++) begin
      if (i == 39) check("b2b_stop1", {31'd0, TxD}, 32'd1);
      if (i == 40) check("b2b_start2", {31'd0, TxD}, 32'd0);
      if (i == 41) rd("b2b_busy", A_ST, 32'h0000_0005);
      tick();
    end
    rd("idle_after_b2b", A_ST, 32'h0000_0001);

    // Overflow: six consecutive pushes, the sixth is dropped.
    MemWrite = 1'b1; Adr = A_TX;
    for (int i = 0; i < 6; i++) begin
      WriteData = 32'h10 + 32'(i);
      tick();
    end
    MemWrite = 1'b0; Adr = A_ST;
    rd("ovf_status", A_ST, 32'h0000_004E);
    wr(A_ST, 32'hFFFF_FFFF);
    rd("ovf_cleared", A_ST, 32'h0000_0046);
    ticks(205);
    rd("drained", A_ST, 32'h0000_0001);

    // Reset in the middle of a frame with a byte still queued.
    wr(A_TX, 32'h33);
    wr(A_TX, 32'h34);
    check("pre_rst_start", {31'd0, TxD}, 32'd0);
    ticks(14);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midrst_txd", {31'd0, TxD}, 32'd1);
    rd("midrst_status", A_ST, 32'h0000_0001);
    ticks(100);
    check("midrst_quiet", {31'd0, TxD}, 32'd1);

    // Accesses outside the window and to the reserved offset.
    wr(32'h0001_FF08, 32'd5);
    wr(32'h0000_FE00, 32'h99);
    wr(A_RSV, 32'hFFFF_FFFF);
    Adr = 32'h0000_FE04; #1;
    check("out_iosel", {31'd0, IoSel}, 32'd0);
    check("out_rdata", IoReadData, 32'd0);
    rd("rsv_read", A_RSV, 32'd0);
    rd("txdata_read", A_TX, 32'd0);
    rd("div_unchanged", A_DIV, 32'd434);
    rd("status_unchanged", A_ST, 32'h0000_0001);
    ticks(3);
    check("out_txd", {31'd0, TxD}, 32'd1);

    // BAUDDIV=0 acts as a 1-cycle bit.
    wr(A_DIV, 32'd0);
    rd("div_zero", A_DIV, 32'd0);
    wr(A_TX, 32'hA5);
    tick();
    check("div0_start", {31'd0, TxD}, 32'd0);
    tick();
    check("div0_bit0", {31'd0, TxD}, 32'd1);
    tick();
    check("div0_bit1", {31'd0, TxD}, 32'd0);
    ticks(9);
    rd("div0_idle", A_ST, 32'h0000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
